// File: rtl/mux_n_1_rr.sv
// N:1 multiplexer with direct-select or round-robin grant into a single output register.
// Latency: 1 clk from input transfer (in_valid & in_ready) to out_valid.
// Backpressure: while the held word is stalled (out_valid & !out_ready), in_ready is all zeros.
module mux_n_1_rr #(
    parameter int N          = 4,
    parameter int WIDTH      = 8,
    localparam int SW        = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic [SW-1:0]      out_ch_q,    out_ch_d;
    logic [SW-1:0]      rr_ptr_q,    rr_ptr_d;

    logic               grant_vld;
    logic [SW-1:0]      grant_idx;
    logic [SW-1:0]      cand_idx;
    logic               can_load;
    logic               load;

    // Round-robin scans upward from the channel after the last winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        if (mode) begin
            for (int i = 1; i <= N; i++) begin
                cand_idx = SW'((int'(rr_ptr_q) + i) % N);
                if (!grant_vld && in_valid[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (sel == SW'(c) && in_valid[c]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(c);
                end
            end
        end
    end

    assign can_load = !out_valid_q || out_ready;
    assign load     = can_load && grant_vld;

    always_comb begin
        in_ready = '0;
        if (rst_n && load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_ch_d    = grant_idx;
            if (mode) begin
                rr_ptr_d = grant_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Bench for mux_n_1_rr: directed scenarios plus random traffic against a reference model.
// Latency: n/a. Backpressure: out_ready driven by the bench.
module tb_mux_n_1_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        mode6;
    logic [2:0]  sel6;
    logic [47:0] in_data6;
    logic [5:0]  in_valid6;
    logic [5:0]  in_ready6;
    logic [7:0]  out_data6;
    logic [2:0]  out_ch6;
    logic        out_valid6;
    logic        out_ready6;

    int errors = 0;
    int checks = 0;

    // reference model state for the N=4 instance
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_last;

    always #5 clk = ~clk;

    mux_n_1_rr #(.N(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_n_1_rr #(.N(6), .WIDTH(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_ch(out_ch6), .out_valid(out_valid6),
        .out_ready(out_ready6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_grant(input logic md, input logic [1:0] s,
                                     input logic [3:0] v, input int last);
        if (md) begin
            for (int k = 1; k <= 4; k++) begin
                if (v[(last + k) % 4]) return (last + k) % 4;
            end
            return -1;
        end
        if (v[s]) return int'(s);
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_last  = 3;
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        int         g;
        logic       acc;
        logic [3:0] exp_rdy;
        #1;
        g       = ref_grant(mode, sel, in_valid, m_last);
        acc     = !m_valid || out_ready;
        exp_rdy = 4'b0000;
        if (acc && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_ch",    32'(out_ch),    32'(m_ch));
        @(posedge clk);
        if (acc && g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_ch    = g;
            if (mode) m_last = g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b1;
        sel        = 2'd0;
        in_data    = 32'h4433_2211;
        in_valid   = 4'hF;
        out_ready  = 1'b1;
        mode6      = 1'b0;
        sel6       = 3'd0;
        in_data6   = '0;
        in_valid6  = '0;
        out_ready6 = 1'b1;
        model_reset();

        // reset state, with valid inputs present
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_in_ready6", 32'(in_ready6), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'h0;
        cycle();

        // T1 direct select of channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        in_data  = 32'h00A5_0000;
        cycle();
        #1;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data",  32'(out_data),  32'hA5);
        chk("t1_out_ch",    32'(out_ch),    32'd2);
        in_valid = 4'h0;
        cycle();
        cycle();

        // T2 round-robin, all valid, restart from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = $urandom;
            cycle();
            #1;
            chk("t2_seq_ch",    32'(out_ch),    32'(i % 4));
            chk("t2_seq_valid", 32'(out_valid), 32'd1);
        end

        // T3 alternating 1,3 then only 1
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            #1;
            chk("t3_alt_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            #1;
            chk("t3_only1_ch",    32'(out_ch),    32'd1);
            chk("t3_only1_valid", 32'(out_valid), 32'd1);
        end

        // T4 back-pressure for 5 clocks with a word held
        in_valid  = 4'hF;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // T5 direct mode with sel on an idle channel, then N=6 channel 5
        mode     = 1'b0;
        sel      = 2'd3;
        in_valid = 4'b0111;
        cycle();
        cycle();
        #1;
        chk("t5_drained", 32'(out_valid), 32'd0);
        sel6      = 3'd5;
        in_valid6 = 6'b100000;
        in_data6  = 48'h5C << 40;
        #1;
        chk("t5_n6_in_ready", 32'(in_ready6), 32'b100000);
        cycle();
        #1;
        chk("t5_n6_valid", 32'(out_valid6), 32'd1);
        chk("t5_n6_data",  32'(out_data6),  32'h5C);
        chk("t5_n6_ch",    32'(out_ch6),    32'd5);
        sel6      = 3'd7;
        in_valid6 = 6'h3F;
        #1;
        chk("t5_n6_sel_oob_ready", 32'(in_ready6), 32'd0);
        cycle();
        #1;
        chk("t5_n6_sel_oob_drain", 32'(out_valid6), 32'd0);
        in_valid6 = '0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        // T6 asynchronous reset mid-stream
        mode      = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_ready", 32'(in_ready),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            #1;
            chk("t6_restart_ch", 32'(out_ch), 32'(i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
